encrypt_input_stager: RTL and testbench

ENCRYPT_INPUT_STAGER -- requirements
Module: encrypt_input_stager

---
 rtl/encrypt_input_stager.sv | 118 +++++++++++
 tb/tb_encrypt_input_stager.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/encrypt_input_stager.sv
// encrypt_input_stager
// Stages plaintext words in a small FIFO ahead of an encryption core and
// pairs each issued word with a per-word key. The key register K is loaded
// only while the FIFO is empty. It rotates left by one bit on every issue,
// so each word leaves with a different key.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous, active-high reset
//   key_in       new key value
//   key_load     load request for key_in
//   key_ready    high when key_load will be accepted (FIFO empty)
//   in_valid     upstream word present on in_data
//   in_data      plaintext word
//   in_ready     stager can accept in_data this cycle
//   out_valid    out_data/out_key valid toward the encryption core
//   out_data     FIFO head (plaintext word)
//   out_key      current key K, paired with out_data
//   out_ready    downstream consumes the head word this cycle
//   level        current FIFO occupancy
//   issue_count  words issued since reset, wraps at 16 bits
module encrypt_input_stager #(
   parameter int N     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N-1:0]               key_in,
   input  logic                       key_load,
   output logic                       key_ready,
   input  logic                       in_valid,
   input  logic [N-1:0]               in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [N-1:0]               out_data,
   output logic [N-1:0]               out_key,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic [15:0]                issue_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [N-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [LW-1:0] r_level;
   logic [N-1:0]  r_key;
   logic [15:0]   r_issue_cnt;

   logic w_accept;
   logic w_issue;
   logic w_key_accept;

   // Handshake decode: all flags derive from registered state only, so an
   // accepted word cannot bypass the FIFO to the output in the same cycle.
   assign in_ready     = (r_level < LW'(DEPTH));
   assign out_valid    = (r_level != '0);
   assign key_ready    = (r_level == '0);
   assign w_accept     = in_valid && in_ready;
   assign w_issue      = out_valid && out_ready;
   assign w_key_accept = key_load && key_ready;

   assign out_data    = r_mem[r_rptr];
   assign out_key     = r_key;
   assign level       = r_level;
   assign issue_count = r_issue_cnt;

   // Storage stage: the data array carries no reset. Stale entries are never
   // visible because out_valid is gated by the reset level.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem[r_wptr] <= in_data;
      end
   end

   // Control stage: pointers and level. DEPTH is a power of two, so the
   // pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_accept) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_issue) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_accept, w_issue})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Key and statistics stage. A key load requires an empty FIFO and an issue
   // requires a non-empty FIFO, so the two branches never compete.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_key       <= '0;
         r_issue_cnt <= '0;
      end else begin
         if (w_key_accept) begin
            r_key <= key_in;
         end else if (w_issue) begin
            r_key <= {r_key[N-2:0], r_key[N-1]};
         end
         if (w_issue) begin
            r_issue_cnt <= r_issue_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_encrypt_input_stager.sv
// Directed testbench for encrypt_input_stager (N=8, DEPTH=4).
module tb_encrypt_input_stager;

   logic        clk;
   logic        rst;
   logic [7:0]  key_in;
   logic        key_load;
   logic        key_ready;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [7:0]  out_key;
   logic        out_ready;
   logic [2:0]  level;
   logic [15:0] issue_count;

   int checks = 0;
   int passes = 0;

   encrypt_input_stager #(.N(8), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .key_in(key_in), .key_load(key_load), .key_ready(key_ready),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_key(out_key),
      .out_ready(out_ready), .level(level), .issue_count(issue_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance one rising edge and settle 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; key_in = '0; key_load = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_key_ready", 32'(key_ready), 32'd1);
      check("rst_out_key", 32'(out_key), 32'h00);
      check("rst_level", 32'(level), 32'd0);
      check("rst_issue_count", 32'(issue_count), 32'd0);
      #10 rst = 1'b0;   // released between edges

      // Load key 81, then stream 11,22,33
      key_load = 1'b1; key_in = 8'h81;
      tick();
      key_load = 1'b0;
      check("key_loaded", 32'(out_key), 32'h81);
      in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
      #1 check("no_bypass", 32'(out_valid), 32'd0);
      tick();
      check("s1_data", 32'(out_data), 32'h11);
      check("s1_key", 32'(out_key), 32'h81);
      in_data = 8'h22;
      tick();
      check("s2_data", 32'(out_data), 32'h22);
      check("s2_key", 32'(out_key), 32'h03);
      in_data = 8'h33;
      tick();
      check("s3_data", 32'(out_data), 32'h33);
      check("s3_key", 32'(out_key), 32'h06);
      in_valid = 1'b0;
      tick();
      check("s_issue_count", 32'(issue_count), 32'd3);
      check("s_level", 32'(level), 32'd0);
      check("s_key_after", 32'(out_key), 32'h0C);

      // Fill and backpressure
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 8'hA1 + 8'(i);
         tick();
      end
      in_valid = 1'b0;
      check("fill_level", 32'(level), 32'd4);
      check("fill_in_ready", 32'(in_ready), 32'd0);
      check("fill_head", 32'(out_data), 32'hA1);
      tick();
      check("stall_head", 32'(out_data), 32'hA1);
      check("stall_key", 32'(out_key), 32'h0C);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_order", 32'(out_data), 32'(8'hA1 + 8'(i)));
         tick();
      end
      check("drain_valid", 32'(out_valid), 32'd0);
      check("drain_issue_count", 32'(issue_count), 32'd7);
      check("drain_key", 32'(out_key), 32'hC0);

      // Simultaneous accept/issue at level 2, across pointer wrap
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 8'hB0; tick();
      in_data = 8'hB1; tick();
      check("sim_level_start", 32'(level), 32'd2);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data = 8'hB2 + 8'(i);
         check("sim_order", 32'(out_data), 32'(8'hB0 + 8'(i)));
         tick();
         check("sim_level", 32'(level), 32'd2);
      end
      in_valid = 1'b0;
      check("sim_tail0", 32'(out_data), 32'hB6);
      tick();
      check("sim_tail1", 32'(out_data), 32'hB7);
      tick();
      check("sim_issue_count", 32'(issue_count), 32'd15);
      check("sim_key", 32'(out_key), 32'hC0);

      // Key load rejected while level=1
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC5;
      tick();
      in_valid = 1'b0;
      key_load = 1'b1; key_in = 8'hFF;
      #1 check("rej_key_ready", 32'(key_ready), 32'd0);
      tick();
      key_load = 1'b0;
      check("rej_key_unchanged", 32'(out_key), 32'hC0);
      out_ready = 1'b1;
      tick();
      check("rej_after_drain_key", 32'(out_key), 32'h81);
      check("rej_after_drain_ready", 32'(key_ready), 32'd1);
      key_load = 1'b1; key_in = 8'h5A;
      tick();
      key_load = 1'b0;
      check("reload_key", 32'(out_key), 32'h5A);

      // Key load and accept in the same cycle
      out_ready = 1'b0;
      key_load = 1'b1; key_in = 8'h3C; in_valid = 1'b1; in_data = 8'hD1;
      tick();
      key_load = 1'b0;
      check("kl_acc_key", 32'(out_key), 32'h3C);
      check("kl_acc_data", 32'(out_data), 32'hD1);
      in_data = 8'hD2; tick();
      in_data = 8'hD3; tick();
      in_valid = 1'b0;
      check("pre_rst_level", 32'(level), 32'd3);

      // Reset mid-stream between edges
      #2 rst = 1'b1;
      #1;
      check("mrst_out_valid", 32'(out_valid), 32'd0);
      check("mrst_level", 32'(level), 32'd0);
      check("mrst_out_key", 32'(out_key), 32'h00);
      check("mrst_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
      check("post_rst_issue_count", 32'(issue_count), 32'd0);
      in_valid = 1'b1; in_data = 8'hE7; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      check("post_rst_accept", 32'(out_data), 32'hE7);
      check("post_rst_level", 32'(level), 32'd1);

      // Issue counter wrap
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b1;
      tick();
      repeat (65535) tick();
      check("wrap_ffff", 32'(issue_count), 32'hFFFF);
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      check("wrap_zero", 32'(issue_count), 32'h0000);
      check("wrap_level", 32'(level), 32'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
